// File: rtl/display_bcd_driver.sv
// Four-digit active-low 7-segment driver for a 32-bit value. An iterative double-dabble
// engine does the binary-to-BCD conversion, and the display blinks while the processor waits for input.
module display_bcd_driver #(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25000000,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Value,
    input  logic        Waiting,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        Overflow,
    output logic        Busy
);

    localparam int DW   = DIGITS * 4;
    localparam int BCDW = 40;
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_r;
    state_t                   state_nx_s;
    logic [31:0]              cap_r;
    logic [31:0]              shift_r;
    logic [BCDW-1:0]          bcd_r;
    logic [4:0]               cnt_r;
    logic [DW-1:0]            disp_r;
    logic [DW-1:0]            disp_nx_s;
    logic                     ovf_r;
    logic                     ovf_nx_s;
    logic                     busy_r;
    logic [BW-1:0]            blink_cnt_r;
    logic [BW-1:0]            blink_cnt_nx_s;
    logic                     phase_r;
    logic                     phase_nx_s;
    logic [DIGITS-1:0][6:0]   hex_r;
    logic [DIGITS-1:0][6:0]   hex_nx_s;
    logic [BCDW-1:0]          bcd_adj_s;
    logic [BCDW-1:0]          bcd_sh_s;
    logic [31:0]              shift_sh_s;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [BCDW-1:0] add3_all(input logic [BCDW-1:0] b);
        logic [BCDW-1:0] r;
        r = b;
        for (int i = 0; i < BCDW / 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Blank phase wins over overflow dashes, which win over digits.
    function automatic logic [DIGITS-1:0][6:0] render(input logic [DW-1:0] digits,
                                                      input logic ovf, input logic blank);
        logic [DIGITS-1:0][6:0] h;
        logic                   lead;
        h    = {DIGITS{SEG_BLANK}};
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (blank) begin
                h[k] = SEG_BLANK;
            end else if (ovf) begin
                h[k] = SEG_DASH;
            end else if (BLANK_LZ && lead && (k != 0) && (digits[4*k +: 4] == 4'd0)) begin
                h[k] = SEG_BLANK;
            end else begin
                h[k] = seg7(digits[4*k +: 4]);
                lead = 1'b0;
            end
        end
        return h;
    endfunction

    assign bcd_adj_s  = add3_all(bcd_r);
    assign bcd_sh_s   = {bcd_adj_s[BCDW-2:0], shift_r[31]};
    assign shift_sh_s = {shift_r[30:0], 1'b0};

    // Next state; the result is committed on the final shift edge, as the FSM enters DONE.
    always_comb begin
        state_nx_s = state_r;
        disp_nx_s  = disp_r;
        ovf_nx_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (Value != cap_r) begin
                    state_nx_s = LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: state_nx_s = SHIFT;
            SHIFT: begin
                if (cnt_r == 5'd31) begin
                    state_nx_s = DONE;
                    disp_nx_s  = bcd_sh_s[DW-1:0];
                    ovf_nx_s   = |bcd_sh_s[BCDW-1:DW];
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Blink counter and phase; leaving the wait state forces the visible phase.
    always_comb begin
        blink_cnt_nx_s = blink_cnt_r;
        phase_nx_s     = phase_r;
        if (Waiting) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_nx_s = {BW{1'b0}};
                phase_nx_s     = ~phase_r;
            end else begin
                blink_cnt_nx_s = blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
                phase_nx_s     = phase_r;
            end
        end else begin
            blink_cnt_nx_s = {BW{1'b0}};
            phase_nx_s     = 1'b0;
        end
        hex_nx_s = render(disp_nx_s, ovf_nx_s, phase_nx_s);
    end

    // FSM state, conversion datapath, committed result and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= IDLE;
            cap_r       <= 32'd0;
            shift_r     <= 32'd0;
            bcd_r       <= {BCDW{1'b0}};
            cnt_r       <= 5'd0;
            disp_r      <= {DW{1'b0}};
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
            blink_cnt_r <= {BW{1'b0}};
            phase_r     <= 1'b0;
            hex_r       <= render({DW{1'b0}}, 1'b0, 1'b0);
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                LOAD: begin
                    cap_r   <= Value;
                    shift_r <= Value;
                    bcd_r   <= {BCDW{1'b0}};
                    cnt_r   <= 5'd0;
                end
                SHIFT: begin
                    bcd_r   <= bcd_sh_s;
                    shift_r <= shift_sh_s;
                    cnt_r   <= cnt_r + 5'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
            disp_r      <= disp_nx_s;
            ovf_r       <= ovf_nx_s;
            busy_r      <= (state_nx_s == LOAD) || (state_nx_s == SHIFT);
            blink_cnt_r <= blink_cnt_nx_s;
            phase_r     <= phase_nx_s;
            hex_r       <= hex_nx_s;
        end
    end

    assign HEX0     = hex_r[0];
    assign HEX1     = hex_r[1];
    assign HEX2     = hex_r[2];
    assign HEX3     = hex_r[3];
    assign Overflow = ovf_r;
    assign Busy     = busy_r;

endmodule
